// File: rtl/top_sch_core.sv
// ---------------------------------------------------------------------------
// top_sch_core
// MFM read-data decoder for the RL02 drive. It recovers half-cells from the
// raw flux pulses, locks onto the zero-bit preamble and finds the sync bit.
// It then assembles LSB-first data bytes until the sector window closes.
//
// Optional feature macro: MFM_ERR_CHECK_EN
//   defined   -> MFM clock-rule checking, ERROR state, sticky mfm_error
//   undefined -> no checking, mfm_error tied low, ERROR never entered
//
// Ports
//   clk_in          : single clock, all logic on its rising edge
//   rst_in          : asynchronous active-low reset
//   Drive_mfm_in    : raw MFM level (high = flux pulse in this half-cell)
//   Drive_sector_in : sector window, active-low (high forces idle)
//   byte_out        : last assembled data byte (held while idle)
//   byte_valid      : one-clock strobe when byte_out updates
//   sync_found      : high from sync-bit detection until the window closes
//   mfm_error       : sticky clock-rule violation flag
// ---------------------------------------------------------------------------
module top_sch_core #(
    parameter int HALF_CELL_CLKS = 8,
    parameter int PREAMBLE_MIN   = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       Drive_mfm_in,
    input  logic       Drive_sector_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       sync_found,
    output logic       mfm_error
);

    localparam int PW = (HALF_CELL_CLKS > 1) ? $clog2(HALF_CELL_CLKS) : 1;
    localparam int CW = $clog2(PREAMBLE_MIN + 1);

    localparam logic [PW-1:0] PH_LAST   = PW'(HALF_CELL_CLKS - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(HALF_CELL_CLKS / 2 - 1);
    localparam logic [CW-1:0] PRE_LOCK  = CW'(PREAMBLE_MIN);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_ERROR    = 2'd3;

    logic          mfm_s1, mfm_s2, mfm_d;
    logic          sec_s1, sec_s2;
    logic          mfm_rise;
    logic [PW-1:0] phase;
    logic          hc_stb, hc_val;
    logic [1:0]    state;
    logic          slot;
    logic          clk_hc;
    logic [CW-1:0] pre_cnt;
    logic          locked;
    logic [6:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          check_hit;

    // Two-flop synchronizers; mfm_d is the extra delay used for edge detection.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mfm_s1 <= 1'b0;
            mfm_s2 <= 1'b0;
            mfm_d  <= 1'b0;
            sec_s1 <= 1'b0;
            sec_s2 <= 1'b0;
        end else begin
            mfm_s1 <= Drive_mfm_in;
            mfm_s2 <= mfm_s1;
            mfm_d  <= mfm_s2;
            sec_s1 <= Drive_sector_in;
            sec_s2 <= sec_s1;
        end
    end

    assign mfm_rise = mfm_s2 & ~mfm_d;

    // Half-cell phase: every flux pulse re-centres the sampling point, and
    // between pulses the counter free-runs to keep half-cell timing.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            phase <= '0;
        end else if (sec_s2 || mfm_rise) begin
            phase <= '0;
        end else if (phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    // One registered half-cell value per half-cell, taken mid-cell.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hc_stb <= 1'b0;
            hc_val <= 1'b0;
        end else begin
            hc_stb <= !sec_s2 && (phase == PH_SAMPLE);
            hc_val <= mfm_s2;
        end
    end

    assign locked = (pre_cnt == PRE_LOCK);

`ifdef MFM_ERR_CHECK_EN
    logic prev_data;
    logic err_q;
    logic violation;

    // A legal MFM clock half-cell is the NOR of the surrounding data bits.
    assign violation = (clk_hc != ~(prev_data | hc_val)) || (clk_hc && hc_val);

    // The sync bit counts as a previous data 1 for the first decoded pair.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prev_data <= 1'b1;
            err_q     <= 1'b0;
        end else if (sec_s2) begin
            prev_data <= 1'b1;
            err_q     <= 1'b0;
        end else if (state != ST_DATA) begin
            prev_data <= 1'b1;
        end else if (hc_stb && slot) begin
            prev_data <= hc_val;
            if (violation) begin
                err_q <= 1'b1;
            end
        end
    end

    assign check_hit = violation;
    assign mfm_error = err_q;
`else
    assign check_hit = 1'b0;
    assign mfm_error = 1'b0;
`endif

    // Decoder FSM. slot=0 expects a clock half-cell, slot=1 its data half-cell.
    // Before lock, only a pulsed half-cell may open a pair, which is how the
    // pair alignment is found from the preamble.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_IDLE;
            slot       <= 1'b0;
            clk_hc     <= 1'b0;
            pre_cnt    <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            sync_found <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (sec_s2) begin
                state      <= ST_IDLE;
                slot       <= 1'b0;
                clk_hc     <= 1'b0;
                pre_cnt    <= '0;
                shreg      <= '0;
                bit_cnt    <= '0;
                sync_found <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_PREAMBLE;
                    end
                    ST_PREAMBLE: begin
                        if (hc_stb) begin
                            if (!slot) begin
                                if (hc_val || locked) begin
                                    clk_hc <= hc_val;
                                    slot   <= 1'b1;
                                end else begin
                                    pre_cnt <= '0;
                                end
                            end else if (locked) begin
                                slot <= 1'b0;
                                if (hc_val) begin
                                    sync_found <= 1'b1;
                                    state      <= ST_DATA;
                                    shreg      <= '0;
                                    bit_cnt    <= '0;
                                end else if (!clk_hc) begin
                                    pre_cnt <= '0;
                                end
                            end else if (hc_val) begin
                                // Two pulses in a row: restart and take this one as a clock.
                                pre_cnt <= '0;
                                clk_hc  <= 1'b1;
                                slot    <= 1'b1;
                            end else begin
                                pre_cnt <= pre_cnt + CW'(1);
                                slot    <= 1'b0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (hc_stb) begin
                            if (!slot) begin
                                clk_hc <= hc_val;
                                slot   <= 1'b1;
                            end else begin
                                slot <= 1'b0;
                                if (check_hit) begin
                                    state <= ST_ERROR;
                                end else begin
                                    shreg   <= {hc_val, shreg[6:1]};
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        byte_out   <= {hc_val, shreg};
                                        byte_valid <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    ST_ERROR: begin
                        state <= ST_ERROR;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_top_sch_core.sv
// ---------------------------------------------------------------------------
// tb_top_sch_core
// Self-checking bench for top_sch_core. It drives MFM half-cell streams and
// compares the decoder outputs against a behavioural sector model.
// The model pairs half-cells after the preamble and finds the sync bit.
// It applies the MFM clock rule and groups data bits into LSB-first bytes.
// Honours MFM_ERR_CHECK_EN so the same bench serves both builds.
// ---------------------------------------------------------------------------
module tb_top_sch_core;

    localparam int HC   = 8;
    localparam int PMIN = 16;
`ifdef MFM_ERR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam logic [23:0] GOLD = 24'h91244A;

    logic       clk_in          = 1'b0;
    logic       rst_in          = 1'b0;
    logic       Drive_mfm_in    = 1'b0;
    logic       Drive_sector_in = 1'b1;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       sync_found;
    logic       mfm_error;

    int tests_run    = 0;
    int tests_failed = 0;

    bit         tail_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         exp_sync;
    bit         exp_err;

    top_sch_core #(
        .HALF_CELL_CLKS(HC),
        .PREAMBLE_MIN  (PMIN)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .Drive_mfm_in   (Drive_mfm_in),
        .Drive_sector_in(Drive_sector_in),
        .byte_out       (byte_out),
        .byte_valid     (byte_valid),
        .sync_found     (sync_found),
        .mfm_error      (mfm_error)
    );

    always #5 clk_in = ~clk_in;

    // Collect every byte strobe, sampled away from the active edge.
    always @(negedge clk_in) begin
        if (byte_valid === 1'b1) got_q.push_back(byte_out);
    end

    task automatic drive_hc(input bit v);
        Drive_mfm_in = v;
        repeat (HC) @(negedge clk_in);
    endtask

    // Preamble of npre zero pairs (pulse, no pulse) followed by tail_q.
    task automatic send(input int npre);
        Drive_sector_in = 1'b0;
        Drive_mfm_in    = 1'b0;
        repeat (5) @(negedge clk_in);
        for (int k = 0; k < npre; k++) begin
            drive_hc(1'b1);
            drive_hc(1'b0);
        end
        foreach (tail_q[k]) drive_hc(tail_q[k]);
        Drive_mfm_in = 1'b0;
    endtask

    task automatic close_sector();
        Drive_mfm_in    = 1'b0;
        Drive_sector_in = 1'b1;
        repeat (6) @(negedge clk_in);
    endtask

    // First n half-cells of a 24-cell pattern, optionally with an extra
    // pulsed half-cell inserted after position inject_after (0 = none).
    task automatic build_tail(input logic [23:0] pat, input int n, input int inject_after);
        logic [23:0] p;
        p = pat;
        tail_q.delete();
        for (int i = 0; i < n; i++) begin
            tail_q.push_back(p[23-i]);
            if (i + 1 == inject_after) tail_q.push_back(1'b1);
        end
    endtask

    // Sector model: a long enough preamble fixes the pair alignment. The
    // first pair with data=1 is the sync bit. Later pairs yield bit=data
    // unless the clock rule is broken, which ends decoding when checking is on.
    task automatic model(input int npre);
        int         i;
        int         nbits;
        bit         synced;
        bit         prev;
        bit         c;
        bit         d;
        logic [7:0] acc;
        exp_q.delete();
        exp_sync = 1'b0;
        exp_err  = 1'b0;
        if (npre >= PMIN) begin
            synced = 1'b0;
            prev   = 1'b1;
            nbits  = 0;
            acc    = 8'h00;
            i      = 0;
            while (i + 1 < tail_q.size() && !exp_err) begin
                c = tail_q[i];
                d = tail_q[i+1];
                i += 2;
                if (!synced) begin
                    if (d) begin
                        synced   = 1'b1;
                        exp_sync = 1'b1;
                        prev     = 1'b1;
                    end
                end else if (CHECK_EN && ((c != !(prev || d)) || (c && d))) begin
                    exp_err = 1'b1;
                end else begin
                    acc[nbits] = d;
                    nbits++;
                    prev = d;
                    if (nbits == 8) begin
                        exp_q.push_back(acc);
                        nbits = 0;
                        acc   = 8'h00;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (4) begin
                @(negedge clk_in);
                Drive_mfm_in    = 1'($urandom);
                Drive_sector_in = 1'($urandom);
            end
            #1;
            tests_run += 4;
            if (byte_out !== 8'h00) begin
                tests_failed++;
                $display("[TB] FAIL reset_byte_out: got %h expected 00", byte_out);
            end
            if (byte_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_byte_valid: got %b expected 0", byte_valid);
            end
            if (sync_found !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_sync_found: got %b expected 0", sync_found);
            end
            if (mfm_error !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_mfm_error: got %b expected 0", mfm_error);
            end
        end
        Drive_mfm_in    = 1'b0;
        Drive_sector_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic test_golden();
        build_tail(GOLD, 24, 0);
        got_q.delete();
        send(46);
        tests_run += 2;
        if (sync_found !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL golden_sync: got %b expected 1", sync_found);
        end
        if (mfm_error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL golden_error: got %b expected 0", mfm_error);
        end
        close_sector();
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL golden_count: got %0d bytes expected 1", got_q.size());
        end else begin
            tests_run++;
            if (got_q[0] !== 8'h52) begin
                tests_failed++;
                $display("[TB] FAIL golden_byte: got %h expected 52", got_q[0]);
            end
        end
    endtask

    task automatic test_injected_error();
        build_tail(GOLD, 24, 7);
        model(46);
        got_q.delete();
        send(46);
        tests_run += 2;
        if (mfm_error !== exp_err) begin
            tests_failed++;
            $display("[TB] FAIL inject_error: got %b expected %b", mfm_error, exp_err);
        end
        if (sync_found !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL inject_sync: got %b expected 1", sync_found);
        end
        Drive_mfm_in    = 1'b0;
        Drive_sector_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        tests_run += 2;
        if (mfm_error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL inject_error_clear: got %b expected 0", mfm_error);
        end
        if (sync_found !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL inject_sync_clear: got %b expected 0", sync_found);
        end
        repeat (4) @(negedge clk_in);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL inject_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                tests_run++;
                if (got_q[k] !== exp_q[k]) begin
                    tests_failed++;
                    $display("[TB] FAIL inject_byte%0d: got %h expected %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_short_preamble();
        build_tail(GOLD, 24, 0);
        got_q.delete();
        send(10);
        tests_run++;
        if (sync_found !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL short_sync: got %b expected 0", sync_found);
        end
        close_sector();
        tests_run++;
        if (got_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL short_count: got %0d bytes expected 0", got_q.size());
        end
    endtask

    task automatic test_window_close();
        build_tail(GOLD, 12, 0);
        got_q.delete();
        send(20);
        tests_run++;
        if (sync_found !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL window_sync: got %b expected 1", sync_found);
        end
        Drive_sector_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        tests_run += 2;
        if (sync_found !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL window_sync_clear: got %b expected 0", sync_found);
        end
        if (mfm_error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL window_error_clear: got %b expected 0", mfm_error);
        end
        repeat (6) @(negedge clk_in);
        tests_run++;
        if (got_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL window_partial: got %0d bytes expected 0", got_q.size());
        end
    endtask

    task automatic test_reset_mid_sector();
        build_tail(GOLD, 24, 0);
        send(46);
        #2;
        rst_in = 1'b0;
        #1;
        tests_run += 3;
        if (byte_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL async_byte_out: got %h expected 00", byte_out);
        end
        if (sync_found !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_sync: got %b expected 0", sync_found);
        end
        if (byte_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_byte_valid: got %b expected 0", byte_valid);
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        got_q.delete();
        send(46);
        close_sector();
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL rehunt_count: got %0d bytes expected 1", got_q.size());
        end else begin
            tests_run++;
            if (got_q[0] !== 8'h52) begin
                tests_failed++;
                $display("[TB] FAIL rehunt_byte: got %h expected 52", got_q[0]);
            end
        end
    endtask

    // Random sectors: random preamble length, random data bits encoded as MFM,
    // a random partial trailing byte and sometimes one corrupted clock half-cell.
    task automatic test_random_sectors();
        int npre;
        int nbits;
        int idx;
        bit prev;
        bit d;
        for (int s = 0; s < 8; s++) begin
            npre  = $urandom_range(PMIN + 12, PMIN + 1);
            nbits = 8 * $urandom_range(3, 1) + $urandom_range(7, 0);
            tail_q.delete();
            tail_q.push_back(1'b1);
            tail_q.push_back(1'b0);
            tail_q.push_back(1'b0);
            tail_q.push_back(1'b1);
            prev = 1'b1;
            for (int b = 0; b < nbits; b++) begin
                d = 1'($urandom);
                tail_q.push_back(!(prev || d));
                tail_q.push_back(d);
                prev = d;
            end
            if ($urandom_range(1, 0) == 1) begin
                idx = 4 + 2 * $urandom_range(nbits - 1, 0);
                tail_q[idx] = !tail_q[idx];
            end
            model(npre);
            got_q.delete();
            send(npre);
            tests_run += 2;
            if (sync_found !== exp_sync) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_sync: got %b expected %b", s, sync_found, exp_sync);
            end
            if (mfm_error !== exp_err) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_error: got %b expected %b", s, mfm_error, exp_err);
            end
            close_sector();
            tests_run++;
            if (got_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_count: got %0d bytes expected %0d", s, got_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[k]) begin
                    tests_run++;
                    if (got_q[k] !== exp_q[k]) begin
                        tests_failed++;
                        $display("[TB] FAIL rand%0d_byte%0d: got %h expected %h", s, k, got_q[k], exp_q[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_injected_error();
        test_short_preamble();
        test_window_close();
        test_reset_mid_sector();
        test_random_sectors();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/top_sch_core.md
TOP_SCH_CORE -- requirements
Module: top_sch

Interface
REQ-001 SHALL expose parameter HALF_CELL_CLKS, default 8, clk_in periods per MFM half-cell.
REQ-002 SHALL expose parameter PREAMBLE_MIN, default 16, consecutive decoded zero bits required for preamble lock.
REQ-003 SHALL have port clk_in input 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in input 1: asynchronous, active-low reset.
REQ-005 SHALL have port Drive_mfm_in input 1: raw MFM read data from the RL02 drive; high level = flux pulse present in the current half-cell.
REQ-006 SHALL have port Drive_sector_in input 1: sector window, active-low; high forces the decoder idle.
REQ-007 SHALL have port byte_out output 8: last assembled data byte.
REQ-008 SHALL have port byte_valid output 1: one-clk_in strobe when byte_out updates.
REQ-009 SHALL have port sync_found output 1: high from sync-bit detection until the sector window closes.
REQ-010 SHALL have port mfm_error output 1: sticky MFM clock-rule violation flag.

Function
REQ-011 SHALL pass Drive_mfm_in and Drive_sector_in through 2-flop synchronizers before use.
REQ-012 SHALL run a modulo-HALF_CELL_CLKS phase counter, cleared to 0 on each synchronized rising edge of Drive_mfm_in and free-running otherwise.
REQ-013 SHALL sample the synchronized MFM level when the phase counter equals HALF_CELL_CLKS/2-1, producing one half-cell value per half-cell.
REQ-014 SHALL implement states IDLE, PREAMBLE, DATA, ERROR.
REQ-015 SHALL stay in IDLE while synchronized Drive_sector_in is high, from any state, clearing all counters, sync_found and mfm_error; byte_out holds its value.
REQ-016 SHALL move IDLE->PREAMBLE when synchronized Drive_sector_in is low.
REQ-017 In PREAMBLE, SHALL treat half-cells alternating pulse/no-pulse as zero bits (clock slot = pulsed half-cell) and count consecutive zeros; any other pattern restarts the count.
REQ-018 SHALL, once the count reaches PREAMBLE_MIN, pair half-cells as (clock, data) on the established alignment; the first pair with data=1 is the sync bit: set sync_found, enter DATA.
REQ-019 In DATA, SHALL decode each (clock, data) pair as bit = data and shift it into an 8-bit register LSB-first.
REQ-020 SHALL, after every 8th bit, load byte_out and assert byte_valid for exactly one clk_in, one clk_in after the sampling edge of that bit's data half-cell.
REQ-021 SHALL treat a pair as a clock-rule violation when clock != NOR(previous data, current data), or clock=data=1; the previous data bit for the first post-sync pair is 1.
REQ-022 On violation, SHALL set mfm_error, enter ERROR, and emit no further byte_valid until IDLE.
REQ-023 SHALL discard an incomplete byte (fewer than 8 bits) when the sector window closes.

Reset
REQ-024 While rst_in is low, SHALL force state IDLE, byte_out=8'h00, byte_valid=0, sync_found=0, mfm_error=0, all counters and synchronizers to 0, regardless of clk_in.
REQ-025 SHALL resume from IDLE on the first clk_in edge after rst_in rises; a sector in progress at reset release is re-hunted from PREAMBLE.

Configuration
REQ-026 With macro MFM_ERR_CHECK_EN defined, SHALL implement REQ-021/REQ-022 and the ERROR state.
REQ-027 Without MFM_ERR_CHECK_EN, SHALL omit violation checking, tie mfm_error to 0, and never enter ERROR.

Verification
REQ-028 Reset: rst_in low with random inputs -> all outputs 0, state IDLE.
REQ-029 Golden sector: Drive_sector_in low, 46 zero pairs (half-cells 1,0 at 8 clocks each), then half-cells 1,0,0,1,0,0,0,1,0,0,1,0,0,1,0,0,0,1,0,0,1,0,1,0 -> sync_found after 2nd pair, one byte_valid with byte_out=8'h52, mfm_error=0.
REQ-030 Injected error: same stream with an extra pulsed half-cell inserted after the 7th post-preamble half-cell -> mfm_error=1 (macro defined), no byte_valid.
REQ-031 Short preamble: only 10 zero pairs then the sync pattern -> sync_found stays 0, no byte_valid.
REQ-032 Window close: raise Drive_sector_in mid-byte -> sync_found and mfm_error clear within 3 clk_in, no byte_valid for the partial byte.
REQ-033 Macro undefined, injected-error stream -> mfm_error stays 0, decoding continues.
